pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, control-flow flush and HI/LO interlock
// against a fixed-latency multiply/divide unit.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_muldiv_start,
  input  logic       id_uses_hilo,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_jump,
  input  logic       ex_jump_register,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  localparam int unsigned CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_CYCLES - 1);

  typedef enum logic {RUN, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic flush, load_use, hilo_haz, normal;

  assign flush    = ex_jump | ex_jump_register;
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign hilo_haz = (state == BUSY) && (id_uses_hilo || id_muldiv_start);
  assign normal   = !flush && !load_use && !hilo_haz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush has no effect on the counter: an issued mult/div always completes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (id_muldiv_start && normal) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    muldiv_busy = 1'b0;
    muldiv_done = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_stall = 1'b1;
    end else begin
      muldiv_busy = (state == BUSY);
      muldiv_done = (state == BUSY) && (cnt == '0);
      if (flush) begin
        ifid_flush = 1'b1;
        idex_stall = 1'b1;
      end else if (load_use || hilo_haz) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table in RUN,
// plus multi-cycle sequences around the mult/div BUSY window.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_muldiv_start, id_uses_hilo;
  logic       ex_mem_read, ex_jump, ex_jump_register;
  logic       pc_write, ifid_write, ifid_flush, idex_stall, muldiv_busy, muldiv_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv_start(id_muldiv_start), .id_uses_hilo(id_uses_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_jump(ex_jump), .ex_jump_register(ex_jump_register),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  // exp order: {pc_write, ifid_write, ifid_flush, idex_stall, muldiv_busy, muldiv_done}
  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, hilo, mem_read;
    logic [4:0] ex_rt;
    logic       jump, jr;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {pc_write, ifid_write, ifid_flush, idex_stall, muldiv_busy, muldiv_done};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (pc,ifid_w,ifid_fl,stall,busy,done)", name, act, exp);
    end
  endtask

  task automatic clr();
    reset = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; id_muldiv_start = 1'b0; id_uses_hilo = 1'b0;
    ex_mem_read = 1'b0; ex_jump = 1'b0; ex_jump_register = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"normal",        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110000};
    tbl[1]  = '{"lu_rs",         5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 6'b000100};
    tbl[2]  = '{"lu_r0",         5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 6'b110000};
    tbl[3]  = '{"rt_unused",     5'd1, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 6'b110000};
    tbl[4]  = '{"rt_used",       5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 6'b000100};
    tbl[5]  = '{"no_match",      5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 6'b110000};
    tbl[6]  = '{"not_load",      5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 6'b110000};
    tbl[7]  = '{"jump",          5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'b111100};
    tbl[8]  = '{"jr",            5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 6'b111100};
    tbl[9]  = '{"flush_lu",      5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 6'b111100};
    tbl[10] = '{"hilo_in_run",   5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b110000};
    tbl[11] = '{"lu_rs_rt_both", 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 6'b000100};

    clr();
    reset = 1'b1;
    @(negedge clk); #2;
    chk("reset_hold", 6'b001100);
    @(negedge clk); reset = 1'b0; #2;
    chk("post_reset", 6'b110000);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clr();
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_uses_rt = tbl[i].uses_rt;
      id_uses_hilo = tbl[i].hilo; ex_mem_read = tbl[i].mem_read; ex_rt = tbl[i].ex_rt;
      ex_jump = tbl[i].jump; ex_jump_register = tbl[i].jr;
      #2;
      chk(tbl[i].name, tbl[i].exp);
    end

    // Load-use stalls one cycle; a mult held in ID meanwhile is not accepted until released.
    @(negedge clk); clr();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_muldiv_start = 1'b1; #2;
    chk("lu_seq_stall", 6'b000100);
    @(negedge clk); ex_mem_read = 1'b0; #2;
    chk("lu_seq_release", 6'b110000);
    @(negedge clk); id_muldiv_start = 1'b0; #2;
    chk("lu_seq_mult_accepted", 6'b110010);
    do_reset();

    // Flush together with load-use: no extra stall afterwards.
    @(negedge clk); clr();
    ex_jump = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; #2;
    chk("flush_lu_seq", 6'b111100);
    @(negedge clk); clr(); id_rs = 5'd8; #2;
    chk("flush_lu_after", 6'b110000);

    // Mult followed by mfhi: 8 BUSY cycles, done on the 8th, mfhi advances next.
    @(negedge clk); clr(); id_muldiv_start = 1'b1; #2;
    chk("mult_issue", 6'b110000);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); id_muldiv_start = 1'b0; id_uses_hilo = 1'b1; #2;
      chk($sformatf("mfhi_busy%0d", i), {5'b00011, (i == 8) ? 1'b1 : 1'b0});
    end
    @(negedge clk); #2;
    chk("mfhi_advance", 6'b110000);

    // Reset on BUSY cycle 3 aborts the operation with no done pulse.
    @(negedge clk); clr(); id_muldiv_start = 1'b1; #2;
    chk("rst_mult_issue", 6'b110000);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); id_muldiv_start = 1'b0; #2;
      chk($sformatf("rst_busy%0d", i), 6'b110010);
    end
    @(negedge clk); reset = 1'b1; #2;
    chk("rst_during_busy", 6'b001100);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); reset = 1'b0; #2;
      chk($sformatf("rst_after%0d", i), 6'b110000);
    end

    // Flush at counter=5 does not disturb the schedule; the stalled mult re-issues.
    @(negedge clk); clr(); id_muldiv_start = 1'b1; #2;
    chk("fl_mult_issue", 6'b110000);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); ex_jump = (i == 3); #2;
      if (i == 3) chk("fl_busy3_flush", 6'b111110);
      else        chk($sformatf("fl_busy%0d", i), {5'b00011, (i == 8) ? 1'b1 : 1'b0});
    end
    @(negedge clk); ex_jump = 1'b0; #2;
    chk("fl_reissue", 6'b110000);
    @(negedge clk); id_muldiv_start = 1'b0; #2;
    chk("fl_rebusy", 6'b110010);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
